fft_batch_ctrl: RTL and testbench

- Parametrised next-generation FFT sequencing controller.
- Accepts a command over a valid/ready handshake: mode FFT, IFFT or FILTER; start signal number; batch count.
- Sequences load-RAM, calculate, optional filter-multiply and inverse pass, and out-FIFO drain per signal, auto-incrementing the signal number across the batch.
- Sits between the host command interface and the FFT datapath, RAM loader and out-FIFO loader.

---
 rtl/fft_ctrl_pkg.sv | 32 +++
 rtl/fft_wdog_timer.sv | 30 +++
 rtl/fft_batch_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_fft_batch_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types for the FFT batch sequencing controller.
package fft_ctrl_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_FFT    = 2'd0,
    MODE_IFFT   = 2'd1,
    MODE_FILTER = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_LOAD_WAIT = 4'd2,
    S_CALC_F    = 4'd3,
    S_FILT      = 4'd4,
    S_CALC_I    = 4'd5,
    S_OUT       = 4'd6,
    S_OUT_WAIT  = 4'd7,
    S_SIG_END   = 4'd8,
    S_DONE      = 4'd9
  } state_t;

  // States that wait on the datapath and may therefore hang.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_LOAD_WAIT) || (s == S_CALC_F) || (s == S_FILT) ||
           (s == S_CALC_I) || (s == S_OUT_WAIT);
  endfunction

endpackage

// File: rtl/fft_wdog_timer.sv
// Per-state watchdog: down-counter reloaded on clear, expires after LIMIT
// enabled cycles without a clear.
module fft_wdog_timer #(
  parameter int LIMIT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] RELOAD = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RELOAD;
    end else if (clear) begin
      cnt <= RELOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = enable && (cnt == '0);

endmodule

// File: rtl/fft_batch_ctrl.sv
// FFT batch sequencing controller: load / calc / filter / inverse / drain per
// signal across a batch. Define FFT_WDOG_EN to add the wait-state watchdog.
//
// state     | meaning
// IDLE      | waiting for a command
// LOAD      | RAM loading from input FIFO
// LOAD_WAIT | input FIFO drained, waiting for load done or resume
// CALC_F    | forward pass
// FILT      | filter multiply
// CALC_I    | inverse pass
// OUT       | draining RAM to out FIFO
// OUT_WAIT  | out FIFO burst done, waiting for drain done or resume
// SIG_END   | signal complete, advance counters
// DONE      | batch end (normal, abort, timeout or reserved mode)
module fft_batch_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int SIG_W       = 18,
  parameter int CNT_W       = 8,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [MODE_W-1:0] cmd_mode,
  input  logic [SIG_W-1:0] cmd_sig_num,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  input  logic             start_load_ram,
  input  logic             in_fifo_empty,
  input  logic             load_ext_done,
  input  logic             calc_done,
  input  logic             filt_done,
  input  logic             start_load_out,
  input  logic             out_fifo_ready,
  input  logic             out_load_done,
  output logic             busy,
  output logic             load_external,
  output logic             load_internal,
  output logic             write_filter,
  output logic             is_ifft,
  output logic             load_out_buffer,
  output logic [SIG_W-1:0] cur_sig_num,
  output logic [CNT_W-1:0] remaining,
  output logic             sig_done,
  output logic             all_done,
  output logic             aborted,
`ifdef FFT_WDOG_EN
  output logic             err_timeout,
`endif
  output logic             cmd_err
);

  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 1");
  end

  state_t           state_q, state_d;
  mode_t            mode_q;
  logic [SIG_W-1:0] sig_q;
  logic [CNT_W-1:0] rem_q;
  logic             abort_q;
  logic             accept;
  logic             timeout;
  logic             force_done;

  assign accept = cmd_valid && (state_q == S_IDLE);

`ifdef FFT_WDOG_EN
  fft_wdog_timer #(
    .LIMIT (WDOG_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_d != state_q),
    .enable  (is_wait_state(state_q)),
    .expired (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_timeout <= 1'b0;
    end else if (accept) begin
      err_timeout <= 1'b0;
    end else if (timeout) begin
      err_timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign force_done = timeout ||
                      (abort && (state_q != S_IDLE) && (state_q != S_DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = (mode_t'(cmd_mode) == MODE_RSVD) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_fifo_empty) state_d = S_LOAD_WAIT;
      end
      S_LOAD_WAIT: begin
        if (load_ext_done) begin
          state_d = (mode_q == MODE_IFFT) ? S_CALC_I : S_CALC_F;
        end else if (start_load_ram) begin
          state_d = S_LOAD;
        end
      end
      S_CALC_F: begin
        if (calc_done) state_d = (mode_q == MODE_FILTER) ? S_FILT : S_OUT;
      end
      S_FILT: begin
        if (filt_done) state_d = S_CALC_I;
      end
      S_CALC_I: begin
        if (calc_done) state_d = S_OUT;
      end
      S_OUT: begin
        if (out_fifo_ready) state_d = S_OUT_WAIT;
      end
      S_OUT_WAIT: begin
        if (out_load_done) begin
          state_d = S_SIG_END;
        end else if (start_load_out) begin
          state_d = S_OUT;
        end
      end
      S_SIG_END: begin
        state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (force_done) state_d = S_DONE;
  end

  // Counters freeze when an abort lands on SIG_END.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_FFT;
      sig_q   <= '0;
      rem_q   <= '0;
      abort_q <= 1'b0;
    end else if (accept) begin
      mode_q  <= mode_t'(cmd_mode);
      sig_q   <= cmd_sig_num;
      rem_q   <= (cmd_count == '0) ? CNT_W'(1) : cmd_count;
      abort_q <= 1'b0;
    end else begin
      if (force_done) abort_q <= 1'b1;
      if ((state_q == S_SIG_END) && !force_done) begin
        sig_q <= sig_q + SIG_W'(1);
        rem_q <= rem_q - CNT_W'(1);
      end
    end
  end

  assign cmd_ready       = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign load_external   = (state_q == S_LOAD);
  assign load_internal   = (state_q == S_CALC_F) || (state_q == S_FILT) ||
                           (state_q == S_CALC_I);
  assign write_filter    = (state_q == S_FILT);
  assign is_ifft         = (state_q == S_CALC_I);
  assign load_out_buffer = (state_q == S_OUT);
  assign sig_done        = (state_q == S_SIG_END);
  assign all_done        = (state_q == S_DONE);
  assign aborted         = (state_q == S_DONE) && abort_q;
  assign cmd_err         = (state_q == S_DONE) && (mode_q == MODE_RSVD);
  assign cur_sig_num     = sig_q;
  assign remaining       = rem_q;

endmodule

// File: tb/tb_fft_batch_ctrl.sv
// Directed bench for fft_batch_ctrl: command table plus stall/abort/reset sequences.
module tb_fft_batch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic [17:0] cmd_sig_num;
  logic [7:0]  cmd_count;
  logic        abort;
  logic        start_load_ram, in_fifo_empty, load_ext_done, calc_done;
  logic        filt_done, start_load_out, out_fifo_ready, out_load_done;
  logic        busy, load_external, load_internal, write_filter, is_ifft;
  logic        load_out_buffer;
  logic [17:0] cur_sig_num;
  logic [7:0]  remaining;
  logic        sig_done, all_done, aborted, cmd_err;
`ifdef FFT_WDOG_EN
  logic        err_timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fft_batch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_mode        (cmd_mode),
    .cmd_sig_num     (cmd_sig_num),
    .cmd_count       (cmd_count),
    .abort           (abort),
    .start_load_ram  (start_load_ram),
    .in_fifo_empty   (in_fifo_empty),
    .load_ext_done   (load_ext_done),
    .calc_done       (calc_done),
    .filt_done       (filt_done),
    .start_load_out  (start_load_out),
    .out_fifo_ready  (out_fifo_ready),
    .out_load_done   (out_load_done),
    .busy            (busy),
    .load_external   (load_external),
    .load_internal   (load_internal),
    .write_filter    (write_filter),
    .is_ifft         (is_ifft),
    .load_out_buffer (load_out_buffer),
    .cur_sig_num     (cur_sig_num),
    .remaining       (remaining),
    .sig_done        (sig_done),
    .all_done        (all_done),
    .aborted         (aborted),
`ifdef FFT_WDOG_EN
    .err_timeout     (err_timeout),
`endif
    .cmd_err         (cmd_err)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [17:0] sig;
    logic [7:0]  cnt;
    int          busy_cyc;
    int          n_sd;
    logic [17:0] first_sd_sig;
    logic [17:0] last_sd_sig;
    logic [17:0] end_sig;
    logic [7:0]  end_rem;
    int          filt_cyc;
    int          ifft_cyc;
    int          ext_cyc;
    int          int_cyc;
    int          n_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_hs(input logic v);
    start_load_ram = v; in_fifo_empty = v; load_ext_done = v; calc_done = v;
    filt_done = v; start_load_out = v; out_fifo_ready = v; out_load_done = v;
  endtask

  // Returns at the negedge following the accepting edge.
  task automatic accept(input logic [1:0] m, input logic [17:0] s, input logic [7:0] c);
    @(negedge clk);
    cmd_mode = m; cmd_sig_num = s; cmd_count = c; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    int busy_c = 0, sd_c = 0, filt_c = 0, ifft_c = 0, ext_c = 0, int_c = 0, err_c = 0;
    logic [17:0] first_sd = '0, last_sd = '0, end_sig = '0;
    logic [7:0] end_rem = '0;
    logic ab = 1'b0;
    bit seen = 0;
    vec_t v = vecs[idx];
    set_hs(1'b1);
    accept(v.mode, v.sig, v.cnt);
    for (int k = 0; k < 200; k++) begin
      if (busy) busy_c++;
      if (write_filter) filt_c++;
      if (is_ifft) ifft_c++;
      if (load_external) ext_c++;
      if (load_internal) int_c++;
      if (cmd_err) err_c++;
      if (sig_done) begin
        if (sd_c == 0) first_sd = cur_sig_num;
        last_sd = cur_sig_num;
        sd_c++;
      end
      if (all_done) begin
        seen = 1; end_sig = cur_sig_num; end_rem = remaining; ab = aborted;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("v%0d all_done seen", idx), 64'(seen), 64'd1);
    chk($sformatf("v%0d busy cycles", idx), 64'(busy_c), 64'(v.busy_cyc));
    chk($sformatf("v%0d sig_done count", idx), 64'(sd_c), 64'(v.n_sd));
    if (v.n_sd > 0) begin
      chk($sformatf("v%0d first sig_done num", idx), 64'(first_sd), 64'(v.first_sd_sig));
      chk($sformatf("v%0d last sig_done num", idx), 64'(last_sd), 64'(v.last_sd_sig));
    end
    chk($sformatf("v%0d end cur_sig_num", idx), 64'(end_sig), 64'(v.end_sig));
    chk($sformatf("v%0d end remaining", idx), 64'(end_rem), 64'(v.end_rem));
    chk($sformatf("v%0d write_filter cycles", idx), 64'(filt_c), 64'(v.filt_cyc));
    chk($sformatf("v%0d is_ifft cycles", idx), 64'(ifft_c), 64'(v.ifft_cyc));
    chk($sformatf("v%0d load_external cycles", idx), 64'(ext_c), 64'(v.ext_cyc));
    chk($sformatf("v%0d load_internal cycles", idx), 64'(int_c), 64'(v.int_cyc));
    chk($sformatf("v%0d cmd_err pulses", idx), 64'(err_c), 64'(v.n_err));
    chk($sformatf("v%0d aborted", idx), 64'(ab), 64'd0);
    @(negedge clk);
    chk($sformatf("v%0d cmd_ready after done", idx), 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    //           mode  sig        cnt  busy sd first     last      end       rem  flt ifft ext int err
    vecs[0] = '{2'd0, 18'd5,     8'd1, 7,  1, 18'd5,     18'd5,    18'd6,    8'd0, 0, 0, 1, 1, 0};
    vecs[1] = '{2'd2, 18'd10,    8'd1, 9,  1, 18'd10,    18'd10,   18'd11,   8'd0, 1, 1, 1, 3, 0};
    vecs[2] = '{2'd1, 18'h3FFFE, 8'd3, 19, 3, 18'h3FFFE, 18'h0,    18'h1,    8'd0, 0, 3, 3, 3, 0};
    vecs[3] = '{2'd3, 18'd7,     8'd5, 1,  0, 18'd0,     18'd0,    18'd7,    8'd5, 0, 0, 0, 0, 1};
    vecs[4] = '{2'd0, 18'd100,   8'd0, 7,  1, 18'd100,   18'd100,  18'd101,  8'd0, 0, 0, 1, 1, 0};
    vecs[5] = '{2'd2, 18'd0,     8'd2, 17, 2, 18'd0,     18'd1,    18'd2,    8'd0, 2, 2, 2, 6, 0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_sig_num = '0; cmd_count = '0;
    abort = 1'b0; set_hs(1'b0);
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset cur_sig_num", 64'(cur_sig_num), 64'd0);
    chk("reset remaining", 64'(remaining), 64'd0);
    chk("reset cmd_ready", 64'(cmd_ready), 64'd1);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Stalls: LOAD/LOAD_WAIT x4, OUT/OUT_WAIT x3.
    set_hs(1'b0);
    accept(2'd0, 18'd20, 8'd1);
    for (int i = 0; i < 4; i++) begin
      chk("stall LOAD load_external", 64'(load_external), 64'd1);
      in_fifo_empty = 1'b1; @(negedge clk); in_fifo_empty = 1'b0;
      chk("stall LOAD_WAIT hold", 64'({busy, load_external, load_internal}), 64'b100);
      start_load_ram = 1'b1; @(negedge clk); start_load_ram = 1'b0;
    end
    chk("stall back in LOAD", 64'(load_external), 64'd1);
    in_fifo_empty = 1'b1; @(negedge clk); in_fifo_empty = 1'b0;
    load_ext_done = 1'b1; @(negedge clk); load_ext_done = 1'b0;
    chk("stall CALC_F decode", 64'({load_internal, is_ifft, write_filter}), 64'b100);
    calc_done = 1'b1; @(negedge clk); calc_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall OUT load_out_buffer", 64'(load_out_buffer), 64'd1);
      out_fifo_ready = 1'b1; @(negedge clk); out_fifo_ready = 1'b0;
      chk("stall OUT_WAIT no sig_done", 64'({load_out_buffer, sig_done, busy}), 64'b001);
      start_load_out = 1'b1; @(negedge clk); start_load_out = 1'b0;
    end
    out_fifo_ready = 1'b1; @(negedge clk); out_fifo_ready = 1'b0;
    out_load_done = 1'b1; @(negedge clk); out_load_done = 1'b0;
    chk("stall SIG_END sig_done", 64'(sig_done), 64'd1);
    chk("stall SIG_END sig num", 64'(cur_sig_num), 64'd20);
    @(negedge clk);
    chk("stall DONE all_done", 64'({all_done, aborted}), 64'b10);
    chk("stall DONE sig num", 64'(cur_sig_num), 64'd21);
    @(negedge clk);

    // Abort in CALC_F of the second signal of a 4-signal batch.
    set_hs(1'b1);
    accept(2'd0, 18'd40, 8'd4);
    repeat (8) @(negedge clk);
    chk("abort pre CALC_F", 64'(load_internal), 64'd1);
    chk("abort pre sig num", 64'(cur_sig_num), 64'd41);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort DONE flags", 64'({all_done, aborted, cmd_ready}), 64'b110);
    chk("abort remaining", 64'(remaining), 64'd3);
    @(negedge clk);
    chk("abort cmd_ready after", 64'({cmd_ready, busy, aborted}), 64'b100);

    // Abort landing on SIG_END freezes the counters.
    accept(2'd0, 18'd50, 8'd2);
    repeat (5) @(negedge clk);
    chk("abort SIG_END reached", 64'(sig_done), 64'd1);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort at SIG_END flags", 64'({all_done, aborted}), 64'b11);
    chk("abort at SIG_END sig num", 64'(cur_sig_num), 64'd50);
    chk("abort at SIG_END remaining", 64'(remaining), 64'd2);
    @(negedge clk);

    // Abort in IDLE is ignored.
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort idle ignored", 64'({busy, all_done, cmd_ready}), 64'b001);

    // Reset mid-batch abandons the batch without all_done.
    accept(2'd0, 18'd60, 8'd3);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("mid reset state", 64'({busy, all_done, cur_sig_num, remaining}), 64'd0);
    @(negedge clk);
    rst = 1'b0; set_hs(1'b0);
    @(negedge clk);
    chk("post reset idle", 64'({busy, all_done, cmd_ready}), 64'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
